// File: rtl/wb_port_arbiter_pkg.sv
// Shared types for the register-file write-port arbiter: data width, register
// address, arbiter FSM states and the buffered long-latency result entry.
package wb_port_arbiter_pkg;

    localparam int XLEN = 32;

    typedef logic [4:0] reg_addr_t;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        FORCE
    } wb_state_e;

    typedef struct packed {
        reg_addr_t         rd;
        logic [XLEN-1:0]   data;
    } wb_entry_t;

endpackage

// File: rtl/wb_port_arbiter_if.sv
// Write-port bundle: writeback stage, long-latency unit return path, decode
// scoreboard queries and the register-file write port.
interface wb_port_arbiter_if;
    import wb_port_arbiter_pkg::*;

    logic              RegWriteW;
    reg_addr_t         RdW;
    logic [XLEN-1:0]   ResultW;
    logic              lu_valid;
    reg_addr_t         lu_rd;
    logic [XLEN-1:0]   lu_data;
    logic              lu_ready;
    reg_addr_t         rs1D;
    reg_addr_t         rs2D;
    logic              rd_pend1;
    logic              rd_pend2;
    logic              stall_req;
    logic              rf_we;
    reg_addr_t         rf_waddr;
    logic [XLEN-1:0]   rf_wdata;

    // Pipeline side: drives W/LU/decode, receives the write port and hazard info.
    modport master (
        output RegWriteW, RdW, ResultW, lu_valid, lu_rd, lu_data, rs1D, rs2D,
        input  lu_ready, rd_pend1, rd_pend2, stall_req, rf_we, rf_waddr, rf_wdata
    );

    modport slave (
        input  RegWriteW, RdW, ResultW, lu_valid, lu_rd, lu_data, rs1D, rs2D,
        output lu_ready, rd_pend1, rd_pend2, stall_req, rf_we, rf_waddr, rf_wdata
    );

endinterface

// File: rtl/wb_port_arbiter_fifo.sv
// Small circular buffer of pending long-latency results; exposes every slot's
// destination and valid bit so the top can run the pending-rd scoreboard.
module wb_port_arbiter_fifo
    import wb_port_arbiter_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  wb_entry_t        push_entry_i,
    input  logic             pop_i,
    output wb_entry_t        head_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CW-1:0]    count_o,
    output reg_addr_t        rd_o [DEPTH],
    output logic [DEPTH-1:0] valid_o
);

    wb_entry_t        mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;
    logic [DEPTH-1:0] valid_q;

    always_comb begin
        count_d = count_q;
        if (push_i && !pop_i) begin
            count_d = count_q + CW'(1);
        end else if (pop_i && !push_i) begin
            count_d = count_q - CW'(1);
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= '0;
        end else begin
            if (pop_i) begin
                rd_ptr_q          <= rd_ptr_q + AW'(1);
                valid_q[rd_ptr_q] <= 1'b0;
            end
            if (push_i) begin
                wr_ptr_q          <= wr_ptr_q + AW'(1);
                valid_q[wr_ptr_q] <= 1'b1;
            end
            count_q <= count_d;
        end
    end

    // NOTE: payload storage has no reset; valid_q alone decides which slots mean anything.
    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= push_entry_i;
        end
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            rd_o[i] = mem_q[i].rd;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: W stage has priority, LU results are buffered
// and drained into free W slots, with a starvation bubble request and rd scoreboard.
module wb_port_arbiter
    import wb_port_arbiter_pkg::*;
#(
    parameter int DEPTH    = 4,
    parameter int MAX_WAIT = 8
) (
    input  logic                clk,
    input  logic                rst,
    wb_port_arbiter_if.slave    bus
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int WW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;

    logic             slot_busy;
    logic             drain;
    logic             bypass;
    logic             push;
    logic             empty_after;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CW-1:0]    fifo_count;
    wb_entry_t        head;
    reg_addr_t        entry_rd [DEPTH];
    logic [DEPTH-1:0] entry_valid;
    logic             pend1;
    logic             pend2;

    wb_state_e        state_q;
    logic [WW-1:0]    wait_cnt_q;
    logic             stall_req_q;

    // A W write to x0 is architecturally a no-op, so that slot is free for the LU.
    assign slot_busy   = bus.RegWriteW && (bus.RdW != '0);
    assign drain       = !slot_busy && !fifo_empty;
    assign bypass      = !slot_busy && fifo_empty && bus.lu_valid;
    assign bus.lu_ready = !fifo_full;
    assign push        = bus.lu_valid && !fifo_full && !bypass && (bus.lu_rd != '0);
    assign empty_after = drain && !push && (fifo_count == CW'(1));

    wb_port_arbiter_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk          (clk),
        .rst          (rst),
        .push_i       (push),
        .push_entry_i ('{rd: bus.lu_rd, data: bus.lu_data}),
        .pop_i        (drain),
        .head_o       (head),
        .full_o       (fifo_full),
        .empty_o      (fifo_empty),
        .count_o      (fifo_count),
        .rd_o         (entry_rd),
        .valid_o      (entry_valid)
    );

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        bus.rf_we    = 1'b0;
        bus.rf_waddr = '0;
        bus.rf_wdata = '0;
        if (!rst) begin
            bus.rf_we = 1'b0;
        end else if (slot_busy) begin
            bus.rf_we    = 1'b1;
            bus.rf_waddr = bus.RdW;
            bus.rf_wdata = bus.ResultW;
        end else if (!fifo_empty) begin
            bus.rf_we    = 1'b1;
            bus.rf_waddr = head.rd;
            bus.rf_wdata = head.data;
        end else if (bus.lu_valid) begin
            bus.rf_we    = (bus.lu_rd != '0);
            bus.rf_waddr = bus.lu_rd;
            bus.rf_wdata = bus.lu_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            wait_cnt_q  <= '0;
            stall_req_q <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (push) begin
                        state_q    <= WAIT;
                        wait_cnt_q <= '0;
                    end
                end
                WAIT: begin
                    if (drain) begin
                        wait_cnt_q <= '0;
                        if (empty_after) state_q <= IDLE;
                    end else if (wait_cnt_q == WW'(MAX_WAIT - 1)) begin
                        state_q     <= FORCE;
                        stall_req_q <= 1'b1;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + WW'(1);
                    end
                end
                FORCE: begin
                    if (drain) begin
                        stall_req_q <= 1'b0;
                        wait_cnt_q  <= '0;
                        state_q     <= empty_after ? IDLE : WAIT;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    stall_req_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.stall_req = stall_req_q;

    always_comb begin
        pend1 = 1'b0;
        pend2 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (entry_valid[i] && (entry_rd[i] == bus.rs1D)) pend1 = 1'b1;
            if (entry_valid[i] && (entry_rd[i] == bus.rs2D)) pend2 = 1'b1;
        end
    end

    assign bus.rd_pend1 = pend1 && (bus.rs1D != '0);
    assign bus.rd_pend2 = pend2 && (bus.rs2D != '0);

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: directed scenarios plus randomized
// traffic compared against a queue-based model of the write-port rules.
module tb_wb_port_arbiter;
    import wb_port_arbiter_pkg::*;

    localparam int DEPTH    = 4;
    localparam int MAX_WAIT = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    wb_port_arbiter_if bus ();

    wb_port_arbiter #(.DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } m_ent_t;

    m_ent_t mq[$];
    int     starve;
    int     n_checks = 0;
    int     n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    endtask

    task automatic drive(input logic rw, input logic [4:0] rdw, input logic [31:0] res,
                         input logic lv, input logic [4:0] lrd, input logic [31:0] ld,
                         input logic [4:0] r1, input logic [4:0] r2);
        bus.RegWriteW = rw;
        bus.RdW       = rdw;
        bus.ResultW   = res;
        bus.lu_valid  = lv;
        bus.lu_rd     = lrd;
        bus.lu_data   = ld;
        bus.rs1D      = r1;
        bus.rs2D      = r2;
    endtask

    function automatic logic model_pend(input logic [4:0] r);
        if (r == 5'd0) return 1'b0;
        foreach (mq[i]) if (mq[i].rd == r) return 1'b1;
        return 1'b0;
    endfunction

    // Compare every output against the model for the current cycle's inputs.
    task automatic sample();
        logic        busy;
        logic        e_we;
        logic [4:0]  e_a;
        logic [31:0] e_d;
        @(negedge clk);
        busy = bus.RegWriteW && (bus.RdW != 5'd0);
        e_we = 1'b0; e_a = '0; e_d = '0;
        if (busy) begin
            e_we = 1'b1; e_a = bus.RdW; e_d = bus.ResultW;
        end else if (mq.size() > 0) begin
            e_we = 1'b1; e_a = mq[0].rd; e_d = mq[0].data;
        end else if (bus.lu_valid) begin
            e_we = (bus.lu_rd != 5'd0); e_a = bus.lu_rd; e_d = bus.lu_data;
        end
        check("rf_we", 32'(bus.rf_we), 32'(e_we));
        if (e_we) begin
            check("rf_waddr", 32'(bus.rf_waddr), 32'(e_a));
            check("rf_wdata", bus.rf_wdata, e_d);
        end
        check("lu_ready", 32'(bus.lu_ready), 32'(mq.size() < DEPTH));
        check("stall_req", 32'(bus.stall_req), 32'(starve >= MAX_WAIT));
        check("rd_pend1", 32'(bus.rd_pend1), 32'(model_pend(bus.rs1D)));
        check("rd_pend2", 32'(bus.rd_pend2), 32'(model_pend(bus.rs2D)));
    endtask

    // Apply the clock edge to the model, then move to just after the DUT edge.
    task automatic advance();
        logic busy, drain, rdy, byp;
        int   pre;
        busy = bus.RegWriteW && (bus.RdW != 5'd0);
        pre  = mq.size();
        drain = !busy && (pre > 0);
        rdy   = (pre < DEPTH);
        byp   = !busy && (pre == 0) && bus.lu_valid;
        if (drain) void'(mq.pop_front());
        if (bus.lu_valid && rdy && !byp && (bus.lu_rd != 5'd0))
            mq.push_back('{rd: bus.lu_rd, data: bus.lu_data});
        if ((pre > 0) && !drain) starve++;
        else starve = 0;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            drive(0, 0, 0, 0, 0, 0, 0, 0);
            sample();
            advance();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        starve = 0;
        drive(1, 5'd3, 32'h1, 1, 5'd4, 32'h2, 5'd4, 5'd3);
        #1;
        check("rst_rf_we", 32'(bus.rf_we), 32'd0);
        check("rst_stall", 32'(bus.stall_req), 32'd0);
        check("rst_lu_ready", 32'(bus.lu_ready), 32'd1);
        check("rst_pend1", 32'(bus.rd_pend1), 32'd0);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Bypass into an idle slot with an empty buffer.
        drive(0, 0, 0, 1, 5'd5, 32'hA5, 5'd5, 0);
        sample();
        check("byp_we", 32'(bus.rf_we), 32'd1);
        check("byp_addr", 32'(bus.rf_waddr), 32'd5);
        check("byp_data", bus.rf_wdata, 32'hA5);
        advance();
        drive(0, 0, 0, 0, 0, 0, 5'd5, 0);
        sample();
        check("byp_not_queued", 32'(bus.rd_pend1), 32'd0);
        advance();

        // W wins, LU result is queued and drained next idle slot.
        drive(1, 5'd3, 32'd7, 1, 5'd4, 32'd9, 5'd4, 0);
        sample();
        check("conf_w_addr", 32'(bus.rf_waddr), 32'd3);
        check("conf_w_data", bus.rf_wdata, 32'd7);
        advance();
        drive(0, 0, 0, 0, 0, 0, 5'd4, 0);
        sample();
        check("conf_pend", 32'(bus.rd_pend1), 32'd1);
        check("conf_drain_addr", 32'(bus.rf_waddr), 32'd4);
        check("conf_drain_data", bus.rf_wdata, 32'd9);
        advance();
        drive(0, 0, 0, 0, 0, 0, 5'd4, 0);
        sample();
        check("conf_pend_clr", 32'(bus.rd_pend1), 32'd0);
        advance();

        // x0 results are accepted but never written; RdW==0 leaves the slot free.
        drive(0, 0, 0, 1, 5'd0, 32'hFF, 0, 0);
        sample();
        check("x0_byp_we", 32'(bus.rf_we), 32'd0);
        advance();
        drive(1, 5'd2, 32'h1, 1, 5'd6, 32'h66, 5'd6, 0);
        sample();
        advance();
        drive(1, 5'd0, 32'hDEAD, 1, 5'd0, 32'hFF, 5'd6, 5'd0);
        sample();
        check("x0_free_addr", 32'(bus.rf_waddr), 32'd6);
        check("x0_free_data", bus.rf_wdata, 32'h66);
        check("x0_ready", 32'(bus.lu_ready), 32'd1);
        advance();
        idle_cycles(2);

        // Fill the buffer while W is busy every cycle.
        for (int i = 0; i < DEPTH; i++) begin
            drive(1, 5'd1, 32'(i), 1, 5'd10 + 5'(i), 32'h100 + 32'(i), 5'd10, 5'd13);
            sample();
            check("fill_ready", 32'(bus.lu_ready), 32'd1);
            advance();
        end
        drive(1, 5'd1, 32'h0, 1, 5'd14, 32'h114, 5'd10, 5'd13);
        sample();
        check("full_ready", 32'(bus.lu_ready), 32'd0);
        advance();
        drive(0, 0, 0, 1, 5'd14, 32'h114, 5'd14, 5'd13);
        sample();
        check("full_pop_ready", 32'(bus.lu_ready), 32'd0);
        check("full_pop_addr", 32'(bus.rf_waddr), 32'd10);
        advance();
        drive(0, 0, 0, 0, 0, 0, 5'd14, 5'd13);
        sample();
        check("full_no_push", 32'(bus.rd_pend1), 32'd0);
        check("full_ready_back", 32'(bus.lu_ready), 32'd1);
        advance();
        idle_cycles(4);

        // Starvation: one entry held off by a busy W stage.
        drive(1, 5'd1, 32'h0, 1, 5'd7, 32'h77, 0, 0);
        sample();
        advance();
        for (int k = 1; k <= 12; k++) begin
            drive(1, 5'd1, 32'(k), 0, 0, 0, 5'd7, 0);
            sample();
            check("starve_stall", 32'(bus.stall_req), 32'(k >= 9));
            advance();
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        sample();
        check("starve_drain_addr", 32'(bus.rf_waddr), 32'd7);
        check("starve_still", 32'(bus.stall_req), 32'd1);
        advance();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        sample();
        check("starve_release", 32'(bus.stall_req), 32'd0);
        advance();

        // Asynchronous reset in the middle of a forced-bubble episode.
        for (int k = 0; k < 12; k++) begin
            drive(1, 5'd1, 32'(k), (k < 3), 5'd20 + 5'(k), 32'(k), 0, 0);
            sample();
            advance();
        end
        drive(1, 5'd2, 32'h5, 1, 5'd22, 32'h5, 5'd20, 5'd21);
        #2;
        rst = 1'b0;
        #1;
        check("mid_rst_we", 32'(bus.rf_we), 32'd0);
        check("mid_rst_stall", 32'(bus.stall_req), 32'd0);
        check("mid_rst_ready", 32'(bus.lu_ready), 32'd1);
        check("mid_rst_pend1", 32'(bus.rd_pend1), 32'd0);
        check("mid_rst_pend2", 32'(bus.rd_pend2), 32'd0);
        mq.delete();
        starve = 0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Randomized traffic with varying W-stage pressure.
        for (int blk = 0; blk < 10; blk++) begin
            int busy_pct;
            case (blk % 4)
                0: busy_pct = 20;
                1: busy_pct = 50;
                2: busy_pct = 80;
                default: busy_pct = 97;
            endcase
            for (int c = 0; c < 200; c++) begin
                drive($urandom_range(99) < busy_pct, 5'($urandom_range(7)), $urandom,
                      $urandom_range(99) < 60, 5'($urandom_range(7)), $urandom,
                      5'($urandom_range(7)), 5'($urandom_range(7)));
                sample();
                advance();
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
